// File: rtl/lsp_expand_pkg.sv
// Purpose : shared types and constants for the LSP minimum-distance expander.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default widths, G.729 gap constants, Q13 saturation limits.
package lsp_expand_pkg;

    localparam int LSP_W_DEF  = 16;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 4;

    // Minimum-distance constants used by Lsp_expand_1 / Lsp_expand_2.
    localparam int GAP1 = 10;
    localparam int GAP2 = 5;

    // 16-bit ITU basic-op saturation limits.
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [2:0] {
        IDLE,
        RD_PREV,
        RD_CUR,
        CAP,
        CALC,
        WR_PREV,
        WR_CUR,
        DONE
    } state_t;

endpackage

// File: rtl/lsp_expand_alu.sv
// Purpose : one expander step: diff = (prev - cur + gap) >>> 1, then prev -= diff, cur += diff.
// Latency : purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports   : prev/cur/gap in (Q13 signed); diffPos, prevNew, curNew out.
// Build   : LSP_EXPAND_SAT_EN defined -> saturating add/sub (ITU add/sub bit-exact),
//           undefined -> add/sub wrap modulo 2^LSP_W.
module lsp_expand_alu
    import lsp_expand_pkg::*;
#(
    parameter int LSP_W = LSP_W_DEF
) (
    input  logic signed [LSP_W-1:0] prev,
    input  logic signed [LSP_W-1:0] cur,
    input  logic signed [LSP_W-1:0] gap,
    output logic                    diffPos,
    output logic signed [LSP_W-1:0] prevNew,
    output logic signed [LSP_W-1:0] curNew
);

`ifdef LSP_EXPAND_SAT_EN
    localparam logic signed [LSP_W-1:0] MAX_V = {1'b0, {(LSP_W-1){1'b1}}};
    localparam logic signed [LSP_W-1:0] MIN_V = {1'b1, {(LSP_W-1){1'b0}}};

    // Result computed one bit wider; a disagreement between the top two bits is overflow.
    function automatic logic signed [LSP_W-1:0] satFit(input logic signed [LSP_W:0] x);
        if (x[LSP_W] != x[LSP_W-1]) begin
            satFit = x[LSP_W] ? MIN_V : MAX_V;
        end else begin
            satFit = x[LSP_W-1:0];
        end
    endfunction

    function automatic logic signed [LSP_W-1:0] addR(input logic signed [LSP_W-1:0] a,
                                                     input logic signed [LSP_W-1:0] b);
        addR = satFit({a[LSP_W-1], a} + {b[LSP_W-1], b});
    endfunction

    function automatic logic signed [LSP_W-1:0] subR(input logic signed [LSP_W-1:0] a,
                                                     input logic signed [LSP_W-1:0] b);
        subR = satFit({a[LSP_W-1], a} - {b[LSP_W-1], b});
    endfunction
`else
    function automatic logic signed [LSP_W-1:0] addR(input logic signed [LSP_W-1:0] a,
                                                     input logic signed [LSP_W-1:0] b);
        addR = a + b;
    endfunction

    function automatic logic signed [LSP_W-1:0] subR(input logic signed [LSP_W-1:0] a,
                                                     input logic signed [LSP_W-1:0] b);
        subR = a - b;
    endfunction
`endif

    logic signed [LSP_W-1:0] diff;

    always_comb begin
        diff    = addR(subR(prev, cur), gap) >>> 1;
        diffPos = !diff[LSP_W-1] && (diff != '0);
        prevNew = subR(prev, diff);
        curNew  = addR(cur, diff);
    end

endmodule

// File: rtl/lsp_expand_range.sv
// Purpose : in-place LSP minimum-distance expansion of buf[lo-1..hi] in scratch memory.
// Latency : done in cycle 2+5N after start (N = hi-lo+1), cycle 1 when lo > hi.
// Backpressure: none; start is ignored while busy, memory assumed always ready (1-cycle read).
// Ports   : clk, reset (async active-low); start/base/lo/hi/gap request; memReadAddr/memIn
//           read port; memWriteAddr/memOut/memWriteEn write port; busy, done status.
// Build   : LSP_EXPAND_SAT_EN selects saturating arithmetic inside lsp_expand_alu.
module lsp_expand_range
    import lsp_expand_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LSP_W  = LSP_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [IDX_W-1:0]  lo,
    input  logic [IDX_W-1:0]  hi,
    input  logic [LSP_W-1:0]  gap,
    output logic [ADDR_W-1:0] memReadAddr,
    input  logic [DATA_W-1:0] memIn,
    output logic [ADDR_W-1:0] memWriteAddr,
    output logic [DATA_W-1:0] memOut,
    output logic              memWriteEn,
    output logic              busy,
    output logic              done
);

    state_t                  state, nxt;
    logic [ADDR_W-1:0]       baseR;
    logic [IDX_W-1:0]        hiR;
    logic signed [LSP_W-1:0] gapR;
    logic [IDX_W:0]          j;          // one spare bit so hi = max index still terminates
    logic                    first;
    logic signed [LSP_W-1:0] prev, cur;
    logic                    diffPosR;

    logic                    diffPos;
    logic signed [LSP_W-1:0] prevNew, curNew;
    logic [IDX_W-1:0]        loEff;
    logic [ADDR_W-1:0]       jAddr;

    // Only the coefficient field of the memory word is meaningful.
    logic unusedMemHi;
    assign unusedMemHi = ^memIn[DATA_W-1:LSP_W];

    assign loEff = (lo == '0) ? IDX_W'(1) : lo;
    assign jAddr = baseR + ADDR_W'(j);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    lsp_expand_alu #(.LSP_W(LSP_W)) uAlu (
        .prev    (prev),
        .cur     (cur),
        .gap     (gapR),
        .diffPos (diffPos),
        .prevNew (prevNew),
        .curNew  (curNew)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (loEff > hi) ? DONE : RD_PREV;
            RD_PREV: nxt = RD_CUR;
            RD_CUR:  nxt = CAP;
            CAP:     nxt = CALC;
            CALC:    nxt = WR_PREV;
            WR_PREV: nxt = WR_CUR;
            WR_CUR:  nxt = ((j + 1'b1) <= {1'b0, hiR}) ? RD_CUR : DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baseR        <= '0;
            hiR          <= '0;
            gapR         <= '0;
            j            <= '0;
            first        <= 1'b0;
            prev         <= '0;
            cur          <= '0;
            diffPosR     <= 1'b0;
            memReadAddr  <= '0;
            memWriteAddr <= '0;
            memOut       <= '0;
            memWriteEn   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        baseR <= base;
                        hiR   <= hi;
                        gapR  <= gap;
                        j     <= {1'b0, loEff};
                        first <= 1'b1;
                        if (loEff <= hi) begin
                            memReadAddr <= base + ADDR_W'(loEff) - ADDR_W'(1);
                        end
                    end
                end
                RD_PREV: memReadAddr <= jAddr;
                RD_CUR: begin
                    // buf[j-1] comes from memory only on the first pair; later it is carried in prev.
                    if (first) prev <= memIn[LSP_W-1:0];
                    first <= 1'b0;
                end
                CAP: begin
                    cur <= memIn[LSP_W-1:0];
                    // Park the read port on the next element so it never aliases the writes to j-1/j.
                    memReadAddr <= jAddr + ADDR_W'(1);
                end
                CALC: begin
                    if (diffPos) begin
                        prev <= prevNew;
                        cur  <= curNew;
                    end
                    diffPosR     <= diffPos;
                    memWriteAddr <= jAddr - ADDR_W'(1);
                    memOut       <= {{(DATA_W-LSP_W){prevNew[LSP_W-1]}}, prevNew};
                    memWriteEn   <= diffPos;
                end
                WR_PREV: begin
                    memWriteAddr <= jAddr;
                    memOut       <= {{(DATA_W-LSP_W){cur[LSP_W-1]}}, cur};
                    memWriteEn   <= diffPosR;
                end
                WR_CUR: begin
                    memWriteEn <= 1'b0;
                    prev       <= cur;
                    j          <= j + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsp_expand_range.sv
// Purpose : directed self-checking bench for lsp_expand_range with a 1-cycle-latency memory model.
// Latency : n/a.
// Backpressure: n/a.
module tb_lsp_expand_range;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [10:0] base = '0;
    logic [3:0]  lo = '0;
    logic [3:0]  hi = '0;
    logic [15:0] gap = '0;
    logic [10:0] memReadAddr;
    logic [31:0] memIn = '0;
    logic [10:0] memWriteAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:2047];
    logic        ldEn = 1'b0;
    logic [10:0] ldAddr = '0;
    logic [31:0] ldDat = '0;
    int          wrCount = 0;
    int          rwClash = 0;

    int vecs = 0;
    int errs = 0;

    lsp_expand_range dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base         (base),
        .lo           (lo),
        .hi           (hi),
        .gap          (gap),
        .memReadAddr  (memReadAddr),
        .memIn        (memIn),
        .memWriteAddr (memWriteAddr),
        .memOut       (memOut),
        .memWriteEn   (memWriteEn),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Scratch memory: read data valid the cycle after the address; bench preload has priority.
    always @(posedge clk) begin
        memIn <= mem[memReadAddr];
        if (ldEn) begin
            mem[ldAddr] <= ldDat;
        end else if (memWriteEn) begin
            mem[memWriteAddr] <= memOut;
        end
        if (memWriteEn) wrCount <= wrCount + 1;
        if (memWriteEn && (memWriteAddr == memReadAddr)) rwClash <= rwClash + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int a, input logic [31:0] d);
        @(negedge clk);
        ldEn = 1'b1; ldAddr = 11'(a); ldDat = d;
        @(negedge clk);
        ldEn = 1'b0;
    endtask

    // Issues one request; start is at the edge ending cycle 0. pokeAt injects a stray start,
    // rstAt pulls reset low in that cycle. doneCyc = -1 when no done was seen.
    task automatic runOp(input int b, input int l, input int h, input int g,
                         input int pokeAt, input int rstAt,
                         output int doneCyc, output int wr);
        int w0;
        w0 = wrCount;
        doneCyc = -1;
        @(negedge clk);
        base = 11'(b); lo = 4'(l); hi = 4'(h); gap = 16'(g); start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = (c == pokeAt);
            if (c == pokeAt) begin
                base = 11'd0; lo = 4'd1; hi = 4'd1;
            end
            if (c == rstAt) begin
                reset = 1'b0;
                #1;
                chk("rstBusy", 32'(busy), 0);
                chk("rstWrEn", 32'(memWriteEn), 0);
                chk("rstRdAddr", 32'(memReadAddr), 0);
                @(negedge clk);
                reset = 1'b1;
                break;
            end
            if (done) begin
                doneCyc = c;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        wr = wrCount - w0;
    endtask

    int dc, wr, extra;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rstBusy0", 32'(busy), 0);
        chk("rstDone0", 32'(done), 0);
        chk("rstWrEn0", 32'(memWriteEn), 0);
        chk("rstRdAddr0", 32'(memReadAddr), 0);
        chk("rstWrAddr0", 32'(memWriteAddr), 0);
        chk("rstMemOut0", memOut, 0);
        reset = 1'b1;

        // Single pair with expansion: diff = (1000-1002+10)>>1 = 4
        put(104, 32'd1000); put(105, 32'd1002);
        runOp(100, 5, 5, 10, 0, 0, dc, wr);
        chk("t1Done", dc, 7);
        chk("t1Writes", wr, 2);
        chk("t1Buf4", mem[104], 32'd996);
        chk("t1Buf5", mem[105], 32'd1006);

        // Already far apart: diff negative, nothing written
        put(104, 32'd1000); put(105, 32'd2000);
        runOp(100, 5, 5, 10, 0, 0, dc, wr);
        chk("t2Done", dc, 7);
        chk("t2Writes", wr, 0);
        chk("t2Buf4", mem[104], 32'd1000);
        chk("t2Buf5", mem[105], 32'd2000);

        // Chain: iteration 2 must see updated buf[1] = 105
        put(200, 32'd100); put(201, 32'd100); put(202, 32'd100);
        runOp(200, 1, 2, 10, 0, 0, dc, wr);
        chk("chainDone", dc, 12);
        chk("chainBuf0", mem[200], 32'd95);
        chk("chainBuf1", mem[201], 32'd98);
        chk("chainBuf2", mem[202], 32'd107);

        // Extremes: saturating vs wrapping arithmetic
        put(300, 32'h0000_7FFF); put(301, 32'hFFFF_8000);
        runOp(300, 1, 1, 10, 0, 0, dc, wr);
        chk("satDone", dc, 7);
`ifdef LSP_EXPAND_SAT_EN
        chk("satPrev", mem[300], 32'h0000_4000);
        chk("satCur", mem[301], 32'hFFFF_BFFF);
`else
        chk("wrapPrev", mem[300], 32'h0000_7FFB);
        chk("wrapCur", mem[301], 32'hFFFF_8004);
`endif

        // Empty window: done in cycle 1, no writes
        runOp(100, 6, 3, 10, 0, 0, dc, wr);
        chk("emptyDone", dc, 1);
        chk("emptyWrites", wr, 0);

        // lo = 0 behaves as lo = 1; element below base untouched
        put(399, 32'd7); put(400, 32'd50); put(401, 32'd50);
        runOp(400, 0, 1, 10, 0, 0, dc, wr);
        chk("lo0Done", dc, 7);
        chk("lo0Below", mem[399], 32'd7);
        chk("lo0Buf0", mem[400], 32'd45);
        chk("lo0Buf1", mem[401], 32'd55);

        // Lsp_expand_2 window, all zeros, gap 5, stray start in cycle 10
        for (int k = 504; k <= 509; k++) put(k, 32'd0);
        runOp(500, 5, 9, 5, 10, 0, dc, wr);
        chk("longDone", dc, 27);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("longNoExtraDone", extra, 0);
        chk("longBuf4", mem[504], 32'hFFFF_FFFE);
        chk("longBuf5", mem[505], 32'hFFFF_FFFF);
        chk("longBuf6", mem[506], 32'hFFFF_FFFF);
        chk("longBuf7", mem[507], 32'd0);
        chk("longBuf8", mem[508], 32'd0);
        chk("longBuf9", mem[509], 32'd4);

        // Reset in cycle 9: only pair j=5 has been written
        for (int k = 604; k <= 609; k++) put(k, 32'd0);
        runOp(600, 5, 9, 5, 0, 9, dc, wr);
        chk("midRstNoDone", dc, 32'hFFFF_FFFF);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || memWriteEn) extra++;
        end
        chk("midRstQuiet", extra, 0);
        chk("midRstBuf4", mem[604], 32'hFFFF_FFFE);
        chk("midRstBuf5", mem[605], 32'd2);
        chk("midRstBuf6", mem[606], 32'd0);

        // Normal run after the aborted one
        put(704, 32'd1000); put(705, 32'd1002);
        runOp(700, 5, 5, 10, 0, 0, dc, wr);
        chk("recDone", dc, 7);
        chk("recBuf4", mem[704], 32'd996);
        chk("recBuf5", mem[705], 32'd1006);

        chk("rwClash", rwClash, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/lsp_expand_range.md
# lsp_expand_range

Parametrised LSP minimum-distance expander for the G.729 quantiser datapath (Qua_Lsp). It replaces the fixed-range Lsp_expand_1/Lsp_expand_2 blocks with one engine. A run-time index window `[lo, hi]` and a run-time `gap` select which adjacent coefficient pairs of a scratch-memory LSP buffer are processed. It operates in place on the buffer through the standard scratch-memory read/write ports.

## Interface
Parameters:
- `ADDR_W`, 11: scratch-memory address width.
- `DATA_W`, 32: scratch-memory word width.
- `LSP_W`, 16: coefficient width; coefficients are Q13 two's complement.
- `IDX_W`, 4: width of the `lo`/`hi` indices.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request, sampled only in IDLE.
- `base`, in, `ADDR_W`: buffer base address; element `k` is at `base + k`.
- `lo`, in, `IDX_W`: first `j` processed.
- `hi`, in, `IDX_W`: last `j` processed.
- `gap`, in, `LSP_W`: minimum-distance constant (GAP1 = 10, GAP2 = 5).
- `memReadAddr`, out, `ADDR_W`: read address, registered.
- `memIn`, in, `DATA_W`: read data; only `[LSP_W-1:0]` is used.
- `memWriteAddr`, out, `ADDR_W`: write address, registered.
- `memOut`, out, `DATA_W`: write data, sign-extended coefficient.
- `memWriteEn`, out, 1: write strobe.
- `busy`, out, 1: high from the start acceptance through the DONE cycle.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- Function, for `j = lo..hi`:
  - `diff = (buf[j-1] - buf[j] + gap) >>> 1`.
  - If `diff > 0`: `buf[j-1] -= diff` and `buf[j] += diff`.
  - Pairs are processed strictly in ascending `j`. Updates from iteration `j` are visible to iteration `j+1`.
- Carry-forward: updated `buf[j]` is held in register `cur` and becomes `prev` for the next iteration. `buf[j-1]` is read from memory only on the first iteration.
- States:
  - IDLE: on `start`, latch `base`, `lo`, `hi`, `gap`, then go to RD_PREV. If `lo > hi`, go directly to DONE.
  - RD_PREV: drive `memReadAddr = base+lo-1`.
  - RD_CUR: drive `memReadAddr = base+j`. Data for the RD_PREV address is captured into `prev` this cycle.
  - CAP: capture `memIn` into `cur`.
  - CALC: compute `diff`; form the new `prev`/`cur`.
  - WR_PREV: if `diff > 0`, write `prev` to `base+j-1`; otherwise `memWriteEn = 0`.
  - WR_CUR: same rule for `cur` at `base+j`. Then `prev <= cur` and `j++`. Go to RD_CUR if `j <= hi`, else DONE.
  - DONE: `done = 1` for one cycle, then IDLE.
- Memory read latency: data for an address driven in cycle N is valid in cycle N+1.
- `lo = 0` is treated as `lo = 1`.
- `start` while busy is ignored.
- Arithmetic: `prev - cur` and `+ gap` are computed at `LSP_W+1` bits, then reduced to `LSP_W` per the Configuration section. `>>>` is arithmetic. Updates use the same add/sub rule.

## Timing
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Reset asserted mid-run: immediate return to IDLE. No further writes occur and no `done` is issued. Memory contents are left as written so far.
- With `N = hi - lo + 1 >= 1` and `start` sampled in cycle 0:
  - RD_PREV in cycle 1.
  - Each pair takes 5 cycles, fixed whether or not writes occur.
  - `done` is high in cycle `2 + 5N`. For `lo=5`, `hi=9`, that is cycle 27.
- With `lo > hi`: `done` is high in cycle 1 and no memory access occurs.
- `memWriteEn` is never high outside WR_PREV/WR_CUR. Read and write never target the same address in the same cycle.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- Macro `LSP_EXPAND_SAT_EN`:
  - Defined: every add/sub saturates to `[-32768, 32767]`, bit-exact with ITU basic ops `add`/`sub`. This is required for G.729 conformance.
  - Undefined: results wrap modulo 2^`LSP_W`, giving a smaller, faster datapath.

## Structure
- `lsp_expand_pkg` holds:
  - the state enum;
  - `LSP_W`/`ADDR_W` defaults;
  - GAP1/GAP2 constants;
  - the `SAT_MAX`/`SAT_MIN` constants.
- Sub-module `lsp_expand_alu` (combinational): takes `prev`, `cur`, `gap` and produces `diff_pos`, `prev_new`, `cur_new`. The `LSP_EXPAND_SAT_EN` choice is confined to this sub-module.

## Test plan
- `lo=5`, `hi=5`, `gap=10`, `buf[4]=1000`, `buf[5]=1002` -> `buf[4]=996`, `buf[5]=1006`; `done` at cycle 7.
- `lo=5`, `hi=5`, `gap=10`, `buf[4]=1000`, `buf[5]=2000` -> no `memWriteEn`; buffer unchanged; `done` at cycle 7.
- Chain `lo=1`, `hi=2`, `gap=10`, `buf[0..2]=100,100,100`:
  - `j=1`: `diff=5`, giving 95, 105.
  - `j=2`: `diff=(105-100+10)>>1=7`, giving 98, 107.
  - Final buffer = 95, 98, 107.
- `prev=32767`, `cur=-32768`, `gap=10`:
  - With SAT_EN: 16384, -16385.
  - Without SAT_EN: 32763, -32764.
- Replay the G.729 vector pair `speech_lsp_expand_2_in/out` (120 frames, `lo=5`, `hi=9`, `gap=5`) -> bit-exact. Run the Lsp_expand_1 vectors with `lo=1`, `hi=4`, `gap=10` -> bit-exact.
- `reset` pulled low in cycle 9 of a `lo=5`, `hi=9` run -> outputs 0 next edge; no `done`. A following `start` completes normally. `start` asserted while busy -> ignored.
